// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and helpers for the mirrored 5x7 LED matrix row side.
package matrix_pkg;

  localparam int ROWS_DEFAULT = 7;

  localparam logic [2:0] COL_OUTER  = 3'b100;
  localparam logic [2:0] COL_INNER  = 3'b010;
  localparam logic [2:0] COL_CENTRE = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW,
    ST_ERROR
  } row_state_t;

  // Image layout: [ROWS-1:0]=centre, [2*ROWS-1:ROWS]=inner, [3*ROWS-1:2*ROWS]=outer.
  function automatic logic [ROWS_DEFAULT-1:0] slice(
    input logic [3*ROWS_DEFAULT-1:0] img,
    input logic [2:0]                col
  );
    logic [ROWS_DEFAULT-1:0] result;
    result = '0;
    case (col)
      COL_OUTER:  result = img[2*ROWS_DEFAULT +: ROWS_DEFAULT];
      COL_INNER:  result = img[ROWS_DEFAULT +: ROWS_DEFAULT];
      COL_CENTRE: result = img[0 +: ROWS_DEFAULT];
      default:    result = '0;
    endcase
    return result;
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    logic result;
    case (v)
      3'b001, 3'b010, 3'b100: result = 1'b1;
      default:                result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/blank_timer.sv
// Loadable down-counter that reports done once it has run down to zero.
module blank_timer #(
  parameter int BLANK_CYCLES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam int CW       = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int LOAD_INT = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_INT);

  logic [CW-1:0] r_cnt;

  // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/row_driver.sv
// Row driver for the mirrored 5x7 matrix: follows the one-hot column select, double-buffers
// the image behind a valid/ready handshake and blanks rows after every column change.
module row_driver
  import matrix_pkg::*;
#(
  parameter int ROWS           = ROWS_DEFAULT,
  parameter int BLANK_CYCLES   = 2,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [2:0]        i_col,
  input  logic [3*ROWS-1:0] i_img_data,
  input  logic              i_img_valid,
  output logic              o_img_ready,
  output logic [ROWS-1:0]   o_rows,
  output logic              o_frame_start,
  output logic              o_col_error
);

  localparam logic [ROWS-1:0] ROWS_OFF = {ROWS{ROW_ACTIVE_LOW}};

  logic [3*ROWS-1:0] r_active;
  logic [3*ROWS-1:0] r_pending;
  logic              r_pending_full;
  logic              r_img_ready;
  logic [2:0]        r_col_q;
  logic [ROWS-1:0]   r_rows;
  logic              r_frame_start;
  logic              r_col_error;
  row_state_t        r_state;

  logic              w_onehot;
  logic              w_change;
  logic              w_boundary;
  logic              w_xfer;
  logic              w_swap;
  logic              w_pending_full_next;
  logic [3*ROWS-1:0] w_active_next;
  logic [ROWS-1:0]   w_slice;
  logic [ROWS-1:0]   w_lit_rows;
  logic              w_timer_load;
  logic              w_timer_en;
  logic              w_blank_done;

  assign w_onehot   = is_onehot3(i_col);
  assign w_change   = (i_col != r_col_q);
  assign w_boundary = w_onehot && w_change && (i_col == COL_OUTER);
  assign w_xfer     = i_img_valid && r_img_ready;
  assign w_swap     = w_boundary && r_pending_full;

  // A transfer can never coincide with a swap: ready is low whenever pending is full.
  assign w_pending_full_next = w_xfer || (r_pending_full && !w_swap);

  // The new image must already feed the outer slice on the swap edge itself.
  assign w_active_next = w_swap ? r_pending : r_active;

  always_comb begin
    w_slice = '0;
    case (i_col)
      COL_OUTER:  w_slice = w_active_next[2*ROWS +: ROWS];
      COL_INNER:  w_slice = w_active_next[ROWS +: ROWS];
      COL_CENTRE: w_slice = w_active_next[0 +: ROWS];
      default:    w_slice = '0;
    endcase
  end

  assign w_lit_rows   = w_slice ^ ROWS_OFF;
  assign w_timer_load = w_onehot && w_change;
  assign w_timer_en   = (r_state == ST_BLANK);

  blank_timer #(
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_blank_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_timer_load),
    .i_en    (w_timer_en),
    .o_done  (w_blank_done)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // NOTE: image buffers are reset too, so a reset really discards both images.
      r_active       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_img_ready    <= 1'b0;
      r_col_q        <= 3'b000;
      r_rows         <= ROWS_OFF;
      r_frame_start  <= 1'b0;
      r_col_error    <= 1'b0;
      r_state        <= ST_IDLE;
    end else begin
      r_col_q        <= i_col;
      r_frame_start  <= w_boundary;
      r_pending_full <= w_pending_full_next;
      r_img_ready    <= !w_pending_full_next;
      if (w_swap) begin
        r_active <= r_pending;
      end
      if (w_xfer) begin
        r_pending <= i_img_data;
      end

      if (!w_onehot) begin
        r_state     <= ST_ERROR;
        r_rows      <= ROWS_OFF;
        r_col_error <= 1'b1;
      end else begin
        r_col_error <= 1'b0;
        if (w_change) begin
          if (BLANK_CYCLES > 0) begin
            r_state <= ST_BLANK;
            r_rows  <= ROWS_OFF;
          end else begin
            r_state <= ST_SHOW;
            r_rows  <= w_lit_rows;
          end
        end else begin
          case (r_state)
            ST_BLANK: begin
              if (w_blank_done) begin
                r_state <= ST_SHOW;
                r_rows  <= w_lit_rows;
              end else begin
                r_rows  <= ROWS_OFF;
              end
            end
            ST_SHOW: begin
              r_rows <= w_lit_rows;
            end
            default: begin
              r_rows <= ROWS_OFF;
            end
          endcase
        end
      end
    end
  end

  assign o_img_ready   = r_img_ready;
  assign o_rows        = r_rows;
  assign o_frame_start = r_frame_start;
  assign o_col_error   = r_col_error;

endmodule

// File: tb/tb_row_driver.sv
// Bench for row_driver: two configurations share one stimulus stream and are checked every
// cycle against a frame-level model, plus literal expectations at the interesting points.
module tb_row_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  col;
  logic [20:0] data;
  logic        valid;

  logic        rdy_a, fs_a, err_a;
  logic [6:0]  rows_a;
  logic        rdy_b, fs_b, err_b;
  logic [6:0]  rows_b;

  always #5 clk = ~clk;

  row_driver #(.ROWS(7), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b0)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_col(col), .i_img_data(data), .i_img_valid(valid),
    .o_img_ready(rdy_a), .o_rows(rows_a), .o_frame_start(fs_a), .o_col_error(err_a)
  );

  row_driver #(.ROWS(7), .BLANK_CYCLES(0), .ROW_ACTIVE_LOW(1'b1)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_col(col), .i_img_data(data), .i_img_valid(valid),
    .o_img_ready(rdy_b), .o_rows(rows_b), .o_frame_start(fs_b), .o_col_error(err_b)
  );

  localparam logic [20:0] IMG_A = 21'h1FC07F; // outer 7F, inner 00, centre 7F
  localparam logic [20:0] IMG_B = 21'h155501; // outer 55, inner 2A, centre 01
  localparam logic [20:0] IMG_C = 21'h045133; // outer 11, inner 22, centre 33
  localparam logic [20:0] IMG_D = 21'h0F07F0; // outer 3C, inner 0F, centre 70
  localparam logic [20:0] IMG_F = 21'h1FA0A2; // outer 7E, inner 41, centre 22

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: current image, a one-deep queue of waiting images, and how many
  // edges the current column has been held.
  logic [20:0] m_active;
  logic [20:0] m_pend[$];
  bit          m_ready, m_fs, m_err, m_live;
  int          m_age;
  logic [2:0]  m_col;

  task automatic model_step();
    bit xfer, oh, chg, bnd;
    if (rst) begin
      m_active = '0;
      m_pend.delete();
      m_ready  = 1'b0;
      m_fs     = 1'b0;
      m_err    = 1'b0;
      m_live   = 1'b0;
      m_age    = 0;
      m_col    = 3'b000;
    end else begin
      xfer = valid && m_ready;
      oh   = ($countones(col) == 1);
      chg  = (col != m_col);
      bnd  = oh && chg && (col == 3'b100);
      m_fs = bnd;
      if (bnd && m_pend.size() > 0) m_active = m_pend.pop_front();
      if (xfer) m_pend.push_back(data);
      m_ready = (m_pend.size() == 0);
      m_err   = !oh;
      if (!oh) m_live = 1'b0;
      else if (chg) begin
        m_live = 1'b1;
        m_age  = 0;
      end else if (m_age < 1000) m_age++;
      m_col = col;
    end
  endtask

  function automatic logic [6:0] exp_rows(input int blank, input bit active_low);
    logic [6:0] lit;
    int sh;
    lit = '0;
    if (m_live && m_age >= blank) begin
      sh  = (m_col == 3'b100) ? 14 : (m_col == 3'b010) ? 7 : 0;
      lit = 7'((m_active >> sh) & 21'h7F);
    end
    return active_low ? ~lit : lit;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rows_a", rows_a, exp_rows(2, 1'b0));
      check("rows_b", rows_b, exp_rows(0, 1'b1));
      check("ready_a", rdy_a, m_ready);
      check("ready_b", rdy_b, m_ready);
      check("fs_a", fs_a, m_fs);
      check("fs_b", fs_b, m_fs);
      check("err_a", err_a, m_err);
      check("err_b", err_b, m_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [20:0] img);
    data  = img;
    valid = 1'b1;
    cyc(1);
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; col = 3'b000; data = '0; valid = 1'b0;
    cyc(3);
    check("rst_rows_a", rows_a, 7'h00);
    check("rst_rows_b", rows_b, 7'h7F);
    check("rst_ready", rdy_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    rst = 1'b0;
    cyc(1);
    check("ready_after_rst", rdy_a, 1'b1);

    // Image A, then one full ring with blanking
    load(IMG_A);
    check("t1_ready_low", rdy_a, 1'b0);
    col = 3'b100; cyc(1);
    check("t1_fs", fs_a, 1'b1);
    check("t1_blank0", rows_a, 7'h00);
    check("t1_noblank_b", rows_b, 7'h00);
    check("t1_swap_ready", rdy_a, 1'b1);
    cyc(1);
    check("t1_fs_once", fs_a, 1'b0);
    check("t1_blank1", rows_a, 7'h00);
    cyc(1);
    check("t1_outer", rows_a, 7'h7F);
    cyc(5);
    col = 3'b010; cyc(1);
    check("t1_inner_b", rows_b, 7'h7F);
    cyc(7);
    col = 3'b001; cyc(2);
    check("t1_c_blank", rows_a, 7'h00);
    cyc(1);
    check("t1_centre", rows_a, 7'h7F);
    cyc(5);

    // Image B loaded mid-frame, live only from the next outer column
    col = 3'b100; cyc(8);
    col = 3'b010; cyc(3);
    load(IMG_B);
    check("t3_ready_low", rdy_a, 1'b0);
    check("t3_inner_old", rows_a, 7'h00);
    cyc(4);
    col = 3'b001; cyc(3);
    check("t3_centre_old", rows_a, 7'h7F);
    check("t3_still_full", rdy_a, 1'b0);
    cyc(5);
    col = 3'b100; cyc(1);
    check("t3_swap_ready", rdy_a, 1'b1);
    check("t3_outer_b", rows_b, 7'h2A);
    cyc(2);
    check("t3_outer_a", rows_a, 7'h55);
    cyc(5);
    col = 3'b010; cyc(3);
    check("t3_inner_new", rows_a, 7'h2A);
    cyc(5);

    // Pending full rejects a second image; a transfer on the boundary waits a frame
    load(IMG_C);
    col = 3'b001; cyc(2);
    data = IMG_D; valid = 1'b1; cyc(3);
    check("t4_reject", rdy_a, 1'b0);
    valid = 1'b0; cyc(3);
    col = 3'b100; cyc(3);
    check("t4_outer_c", rows_a, 7'h11);
    check("t4_ready", rdy_a, 1'b1);
    cyc(5);
    col = 3'b010; cyc(8);
    col = 3'b001; cyc(8);
    col = 3'b100; data = IMG_D; valid = 1'b1; cyc(1);
    valid = 1'b0;
    check("t4_bnd_fs", fs_a, 1'b1);
    check("t4_bnd_full", rdy_a, 1'b0);
    cyc(2);
    check("t4_still_c", rows_a, 7'h11);
    cyc(5);
    col = 3'b010; cyc(8);
    col = 3'b001; cyc(8);
    col = 3'b100; cyc(3);
    check("t4_outer_d", rows_a, 7'h3C);
    cyc(5);

    // Invalid columns with an image waiting
    col = 3'b010; cyc(3);
    load(IMG_F);
    col = 3'b110; cyc(1);
    check("t5_err", err_a, 1'b1);
    check("t5_off_a", rows_a, 7'h00);
    check("t5_off_b", rows_b, 7'h7F);
    cyc(2);
    col = 3'b000; cyc(2);
    check("t5_err_zero", err_a, 1'b1);
    col = 3'b010; cyc(1);
    check("t5_err_clear", err_a, 1'b0);
    check("t5_no_fs", fs_a, 1'b0);
    check("t5_blank", rows_a, 7'h00);
    check("t5_inner_b", rows_b, 7'h70);
    cyc(2);
    check("t5_inner_a", rows_a, 7'h0F);
    check("t5_no_swap", rdy_a, 1'b0);
    cyc(5);

    // Reset while showing with a full pending buffer
    rst = 1'b1; cyc(1);
    check("t6_rows_off", rows_a, 7'h00);
    check("t6_rows_off_b", rows_b, 7'h7F);
    check("t6_ready", rdy_a, 1'b0);
    rst = 1'b0;
    col = 3'b100; cyc(1);
    check("t6_ready_up", rdy_a, 1'b1);
    check("t6_fs", fs_a, 1'b1);
    check("t6_blank_img", rows_b, 7'h7F);
    cyc(2);
    check("t6_blank_img_a", rows_a, 7'h00);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
